fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage. Owns the program counter and drives the combinational
//  instruction memory address. Registers each fetched {pc, instruction} pair into
//  an IF/ID output register with a valid/ready handshake toward decode.
//  Accepts control-flow redirects from execute and halts on an illegal fetch address.
// PARAMETERS
//  ResetVector      32'h0000_0000  PC value loaded on reset
//  MemoryBytesSize  64             instruction memory size in bytes; must match the imem instance
// PORTS
//  i_clk               in   1   clock, all state updates on posedge
//  i_rst_n             in   1   synchronous reset, active-low
//  o_imem_addr         out  32  byte address to instruction memory (= pc_q, combinational)
//  i_imem_instruction  in   32  instruction word returned combinationally for o_imem_addr
//  i_redirect_valid    in   1   flush and load new PC this cycle
//  i_redirect_pc       in   32  redirect target byte address
//  o_if_valid          out  1   IF/ID register holds an instruction
//  o_if_pc             out  32  PC of the held instruction
//  o_if_instruction    out  32  held instruction word
//  i_if_ready          in   1   decode accepts the held instruction this cycle
//  o_fault             out  1   sticky: fetch attempted at an illegal PC
//  o_fault_pc          out  32  PC that caused the fault
// BEHAVIOUR
//  - Single clock, i_clk. Reset is synchronous, active-low on i_rst_n: sampled at posedge.
//  - Reset values: pc_q=ResetVector, state=FETCH, o_if_valid=0, o_if_pc=0,
//    o_if_instruction=0, o_fault=0, o_fault_pc=0.
//  - legal(pc) = (pc[1:0]==2'b00) && (pc <= MemoryBytesSize-4). Compare in 33 bits.
//  - slot_free = !o_if_valid || i_if_ready. A handshake occurs when o_if_valid && i_if_ready.
//  - FSM has two states, FETCH and HALT. Priority per cycle, highest first:
//    1. i_redirect_valid:
//       - Set pc_q<=i_redirect_pc, o_if_valid<=0, state<=FETCH, o_fault<=0.
//       - The held instruction is dropped unless handshaken this same cycle.
//       - No new instruction is loaded this cycle.
//    2. FETCH && slot_free && legal(pc_q):
//       - Load o_if_pc<=pc_q, o_if_instruction<=i_imem_instruction, o_if_valid<=1.
//       - Set pc_q<=pc_q+4. The add wraps mod 2^32; a wrapped value is illegal.
//    3. FETCH && slot_free && !legal(pc_q):
//       - Set state<=HALT, o_fault<=1, o_fault_pc<=pc_q, o_if_valid<=0.
//    4. Otherwise (stall or HALT): pc_q and the IF/ID register hold.
//       o_if_valid clears if a handshake occurred.
//  - Latency: the first o_if_valid is seen one cycle after i_rst_n is sampled high.
//  - Throughput is one instruction per cycle while i_if_ready=1.
//  - Stall: while o_if_valid=1 && i_if_ready=0, o_if_pc and o_if_instruction stay stable.
//    o_imem_addr also stays stable.
//  - HALT is left only by a redirect or by reset. In HALT, o_imem_addr=pc_q (the faulting PC).
//  - Reset asserted mid-operation overrides a simultaneous redirect or handshake.
// TESTING
//  1. Reset, ResetVector=0, imem words W0..W3, i_if_ready=1 -> o_if_valid=1 from cycle 1.
//     Expect (pc,instr)=(0,W0),(4,W1),(8,W2),(12,W3), one per cycle.
//  2. Drop i_if_ready for 3 cycles while holding pc=8 -> o_if_pc=8 and instr W2 held stable.
//     o_imem_addr=12 throughout. After ready returns, next is (12,W3).
//  3. Redirect to 0x20 while holding pc=4 with i_if_ready=0 -> next cycle o_if_valid=0,
//     o_imem_addr=0x20. The cycle after, expect (0x20,W8). pc=4 is never handshaken.
//  4. MemoryBytesSize=64, sequential fetch reaches pc=60 and is accepted -> at pc=64, o_fault=1,
//     o_fault_pc=64, o_if_valid=0, and no further valid outputs.
//  5. Redirect to 0x06 -> o_fault=1, o_fault_pc=6. A later redirect to 0x10 -> o_fault=0.
//     Fetch resumes at (0x10,W4).
//  6. Assert i_rst_n=0 in the same cycle as a redirect and a handshake -> all outputs take
//     reset values. pc restarts at ResetVector.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// registers {pc, instruction} into an IF/ID slot with a valid/ready handshake.
module fetch_stage #(
  parameter logic [31:0] ResetVector     = 32'h0000_0000,
  parameter int unsigned MemoryBytesSize = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instruction,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instruction,
  input  logic        i_if_ready,
  output logic        o_fault,
  output logic [31:0] o_fault_pc
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_t;

  localparam logic [32:0] LastWordAddr = 33'(MemoryBytesSize) - 33'd4;

  // Word-aligned and inside memory; a PC that wrapped past 2^32 is never legal.
  function automatic logic pc_legal(input logic [31:0] pc, input logic wrapped);
    pc_legal = (pc[1:0] == 2'b00) && ({1'b0, pc} <= LastWordAddr) && !wrapped;
  endfunction

  state_t      state_r,  state_s;
  logic [31:0] pc_r,     pc_s;
  logic        wrap_r,   wrap_s;
  logic        valid_r,  valid_s;
  logic [31:0] if_pc_r,  if_pc_s;
  logic [31:0] instr_r,  instr_s;
  logic        fault_r,  fault_s;
  logic [31:0] fpc_r,    fpc_s;

  logic        slot_free_s;
  logic        handshake_s;
  logic [32:0] pc_inc_s;

  assign slot_free_s = !valid_r || i_if_ready;
  assign handshake_s = valid_r && i_if_ready;
  assign pc_inc_s    = {1'b0, pc_r} + 33'd4;

  // Next-state selection in priority order: redirect, fetch, fault, hold.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    wrap_s  = wrap_r;
    valid_s = valid_r;
    if_pc_s = if_pc_r;
    instr_s = instr_r;
    fault_s = fault_r;
    fpc_s   = fpc_r;
    if (i_redirect_valid) begin
      pc_s    = i_redirect_pc;
      wrap_s  = 1'b0;
      valid_s = 1'b0;
      state_s = ST_FETCH;
      fault_s = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (slot_free_s && pc_legal(pc_r, wrap_r)) begin
            if_pc_s = pc_r;
            instr_s = i_imem_instruction;
            valid_s = 1'b1;
            pc_s    = pc_inc_s[31:0];
            wrap_s  = pc_inc_s[32];
          end else if (slot_free_s) begin
            state_s = ST_HALT;
            fault_s = 1'b1;
            fpc_s   = pc_r;
            valid_s = 1'b0;
          end else begin
            valid_s = valid_r;
          end
        end
        ST_HALT: begin
          if (handshake_s) begin
            valid_s = 1'b0;
          end else begin
            valid_s = valid_r;
          end
        end
        default: begin
          state_s = ST_HALT;
          valid_s = 1'b0;
        end
      endcase
    end
  end

  // State register; reset wins over any redirect or handshake in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_FETCH;
      pc_r    <= ResetVector;
      wrap_r  <= 1'b0;
      valid_r <= 1'b0;
      if_pc_r <= 32'h0000_0000;
      instr_r <= 32'h0000_0000;
      fault_r <= 1'b0;
      fpc_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      wrap_r  <= wrap_s;
      valid_r <= valid_s;
      if_pc_r <= if_pc_s;
      instr_r <= instr_s;
      fault_r <= fault_s;
      fpc_r   <= fpc_s;
    end
  end

  assign o_imem_addr      = pc_r;
  assign o_if_valid       = valid_r;
  assign o_if_pc          = if_pc_r;
  assign o_if_instruction = instr_r;
  assign o_fault          = fault_r;
  assign o_fault_pc       = fpc_r;

endmodule
